pipeline_ctrl: RTL and testbench

//  Central stall/kill/redirect sequencer for the IF-ID-DP front end. Replaces the tied-off stall_*/kill_* nets in the core top.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/pipeline_ctrl_sat_cnt.sv | 19 +
 rtl/pipeline_ctrl.sv | 114 +++++++++++
 tb/tb_pipeline_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the front-end stall/kill/redirect sequencer.
package pipeline_ctrl_pkg;

   localparam int unsigned ADDR_LEN = 32;

   localparam int unsigned RS_ALU    = 0;
   localparam int unsigned RS_BRANCH = 1;
   localparam int unsigned RS_MUL    = 2;
   localparam int unsigned RS_LDST   = 3;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_RECOVER = 2'd2,
      ST_DRAIN   = 2'd3
   } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipeline_ctrl_sat_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         count_o <= '0;
      end else if (inc_i && (count_o != {CNT_W{1'b1}})) begin
         count_o <= count_o + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/kill/redirect sequencer for IF-ID-DP: resource stalls, fence drain,
// and mispredict flush followed by a fixed-length rename recovery hold.
module pipeline_ctrl #(
   parameter int unsigned ADDR_LEN       = pipeline_ctrl_pkg::ADDR_LEN,
   parameter int unsigned RS_TYPES       = 4,
   parameter int unsigned RECOVER_CYCLES = 2,
   parameter int unsigned CNT_W          = 32
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                dp_valid_i,
   input  logic [RS_TYPES-1:0] dp_req_i,
   input  logic                dp_serialize_i,
   input  logic                rrf_allocatable_i,
   input  logic [RS_TYPES-1:0] rs_full_i,
   input  logic                rob_full_i,
   input  logic                rob_empty_i,
   input  logic                br_valid_i,
   input  logic                br_mispredict_i,
   input  logic [ADDR_LEN-1:0] br_target_i,
   output logic                stall_IF_o,
   output logic                stall_ID_o,
   output logic                stall_DP_o,
   output logic                kill_IF_o,
   output logic                kill_ID_o,
   output logic                kill_DP_o,
   output logic                redirect_valid_o,
   output logic [ADDR_LEN-1:0] redirect_pc_o,
   output logic                recover_o,
   output logic [1:0]          state_o,
   output logic [CNT_W-1:0]    stall_cycles_o
);

   import pipeline_ctrl_pkg::*;

   localparam int unsigned REC_W = $clog2(RECOVER_CYCLES + 1);

   ctrl_state_e      state_q, state_d;
   logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
   logic             res_stall, ser_stall, mispredict;
   logic             stall_c, kill_c, redirect_c, recover_c;

   assign res_stall  = dp_valid_i & (~rrf_allocatable_i | rob_full_i | (|(dp_req_i & rs_full_i)));
   assign ser_stall  = dp_valid_i & dp_serialize_i & ~rob_empty_i;
   assign mispredict = br_valid_i & br_mispredict_i;

   // Next-state and per-state control; a mispredict overrides every transition.
   always_comb begin
      state_d    = state_q;
      rec_cnt_d  = rec_cnt_q;
      stall_c    = 1'b0;
      kill_c     = 1'b0;
      redirect_c = 1'b0;
      recover_c  = 1'b0;
      case (state_q)
         ST_RUN: begin
            stall_c = res_stall | ser_stall;
            if (ser_stall) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            stall_c = 1'b1;
            if (rob_empty_i) state_d = ST_RUN;
         end
         ST_FLUSH: begin
            kill_c     = 1'b1;
            redirect_c = 1'b1;
            recover_c  = 1'b1;
            state_d    = ST_RECOVER;
            rec_cnt_d  = REC_W'(RECOVER_CYCLES);
         end
         ST_RECOVER: begin
            stall_c   = 1'b1;
            recover_c = 1'b1;
            rec_cnt_d = rec_cnt_q - REC_W'(1);
            if (rec_cnt_q == REC_W'(1)) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      if (mispredict) state_d = ST_FLUSH;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= ST_RUN;
         rec_cnt_q     <= '0;
         redirect_pc_o <= '0;
      end else begin
         state_q   <= state_d;
         rec_cnt_q <= rec_cnt_d;
         if (mispredict) redirect_pc_o <= br_target_i;
      end
   end

   // Reset silences all control strobes, including while an old state is still held.
   assign stall_IF_o       = stall_c & ~reset_i;
   assign stall_ID_o       = stall_c & ~reset_i;
   assign stall_DP_o       = stall_c & ~reset_i;
   assign kill_IF_o        = kill_c & ~reset_i;
   assign kill_ID_o        = kill_c & ~reset_i;
   assign kill_DP_o        = kill_c & ~reset_i;
   assign redirect_valid_o = redirect_c & ~reset_i;
   assign recover_o        = recover_c & ~reset_i;
   assign state_o          = state_q;

   pipeline_ctrl_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_i   (clk_i),
      .clear_i (reset_i),
      .inc_i   (stall_DP_o),
      .count_o (stall_cycles_o)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a behavioural model.
module tb_pipeline_ctrl;

   localparam int unsigned AL = 32;
   localparam int unsigned RT = 4;
   localparam int unsigned RC = 2;

   logic          clk = 1'b0;
   logic          reset_i, dp_valid_i, dp_serialize_i, rrf_allocatable_i;
   logic [RT-1:0] dp_req_i, rs_full_i;
   logic          rob_full_i, rob_empty_i, br_valid_i, br_mispredict_i;
   logic [AL-1:0] br_target_i;

   logic          stall_IF_o, stall_ID_o, stall_DP_o, kill_IF_o, kill_ID_o, kill_DP_o;
   logic          redirect_valid_o, recover_o;
   logic [AL-1:0] redirect_pc_o;
   logic [1:0]    state_o;
   logic [31:0]   stall_cycles_o;

   logic          s4_if, s4_id, s4_dp, k4_if, k4_id, k4_dp, rv4, rec4;
   logic [AL-1:0] pc4;
   logic [1:0]    st4;
   logic [3:0]    cnt4;

   logic [9:0]    obs, obs4;
   assign obs  = {stall_IF_o, stall_ID_o, stall_DP_o, kill_IF_o, kill_ID_o, kill_DP_o,
                  redirect_valid_o, recover_o, state_o};
   assign obs4 = {s4_if, s4_id, s4_dp, k4_if, k4_id, k4_dp, rv4, rec4, st4};

   int n_cmp = 0;
   int n_err = 0;

   // Model: phase flags rather than an encoded state
   bit          m_flush, m_drain;
   int          m_rec;
   logic [AL-1:0] m_pc;
   longint      m_cnt;
   int          m_cnt4;

   always #5 clk = ~clk;

   pipeline_ctrl #(.ADDR_LEN(AL), .RS_TYPES(RT), .RECOVER_CYCLES(RC), .CNT_W(32)) u_dut (
      .clk_i(clk), .reset_i(reset_i), .dp_valid_i(dp_valid_i), .dp_req_i(dp_req_i),
      .dp_serialize_i(dp_serialize_i), .rrf_allocatable_i(rrf_allocatable_i),
      .rs_full_i(rs_full_i), .rob_full_i(rob_full_i), .rob_empty_i(rob_empty_i),
      .br_valid_i(br_valid_i), .br_mispredict_i(br_mispredict_i), .br_target_i(br_target_i),
      .stall_IF_o(stall_IF_o), .stall_ID_o(stall_ID_o), .stall_DP_o(stall_DP_o),
      .kill_IF_o(kill_IF_o), .kill_ID_o(kill_ID_o), .kill_DP_o(kill_DP_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .recover_o(recover_o), .state_o(state_o), .stall_cycles_o(stall_cycles_o));

   pipeline_ctrl #(.ADDR_LEN(AL), .RS_TYPES(RT), .RECOVER_CYCLES(RC), .CNT_W(4)) u_dut4 (
      .clk_i(clk), .reset_i(reset_i), .dp_valid_i(dp_valid_i), .dp_req_i(dp_req_i),
      .dp_serialize_i(dp_serialize_i), .rrf_allocatable_i(rrf_allocatable_i),
      .rs_full_i(rs_full_i), .rob_full_i(rob_full_i), .rob_empty_i(rob_empty_i),
      .br_valid_i(br_valid_i), .br_mispredict_i(br_mispredict_i), .br_target_i(br_target_i),
      .stall_IF_o(s4_if), .stall_ID_o(s4_id), .stall_DP_o(s4_dp),
      .kill_IF_o(k4_if), .kill_ID_o(k4_id), .kill_DP_o(k4_dp),
      .redirect_valid_o(rv4), .redirect_pc_o(pc4),
      .recover_o(rec4), .state_o(st4), .stall_cycles_o(cnt4));

   function automatic logic [9:0] model_outs();
      logic res, ser, s, k, rv, rec;
      logic [1:0] st;
      res = dp_valid_i & (~rrf_allocatable_i | rob_full_i | (|(dp_req_i & rs_full_i)));
      ser = dp_valid_i & dp_serialize_i & ~rob_empty_i;
      s = 1'b0; k = 1'b0; rv = 1'b0; rec = 1'b0;
      if (m_flush)        begin k = 1'b1; rv = 1'b1; rec = 1'b1; st = 2'd1; end
      else if (m_rec > 0) begin s = 1'b1; rec = 1'b1; st = 2'd2; end
      else if (m_drain)   begin s = 1'b1; st = 2'd3; end
      else                begin s = res | ser; st = 2'd0; end
      if (reset_i) begin s = 1'b0; k = 1'b0; rv = 1'b0; rec = 1'b0; end
      return {s, s, s, k, k, k, rv, rec, st};
   endfunction

   task automatic model_edge();
      logic [9:0] e;
      e = model_outs();
      if (reset_i) begin
         m_flush = 0; m_drain = 0; m_rec = 0; m_pc = '0; m_cnt = 0; m_cnt4 = 0;
      end else begin
         if (e[7]) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
         end
         if (br_valid_i & br_mispredict_i) begin
            m_flush = 1; m_rec = 0; m_drain = 0; m_pc = br_target_i;
         end else if (m_flush) begin
            m_flush = 0; m_rec = RC;
         end else if (m_rec > 0) begin
            m_rec--;
         end else if (m_drain) begin
            if (rob_empty_i) m_drain = 0;
         end else if (dp_valid_i & dp_serialize_i & ~rob_empty_i) begin
            m_drain = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_quiet();
      reset_i = 0; dp_valid_i = 0; dp_req_i = '0; dp_serialize_i = 0;
      rrf_allocatable_i = 1; rs_full_i = '0; rob_full_i = 0; rob_empty_i = 1;
      br_valid_i = 0; br_mispredict_i = 0; br_target_i = '0;
   endtask

   task automatic randomize_inputs();
      dp_valid_i        = 1'($urandom_range(0, 1));
      dp_req_i          = RT'(1) << $urandom_range(0, RT - 1);
      dp_serialize_i    = ($urandom_range(0, 5) == 0);
      rrf_allocatable_i = ($urandom_range(0, 4) != 0);
      rs_full_i         = RT'($urandom);
      rob_full_i        = ($urandom_range(0, 5) == 0);
      rob_empty_i       = ($urandom_range(0, 2) == 0);
      br_valid_i        = ($urandom_range(0, 3) == 0);
      br_mispredict_i   = ($urandom_range(0, 2) == 0);
      br_target_i       = $urandom;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         randomize_inputs();
         reset_i = 1;
         tick();
         n_cmp++;
         if (obs !== 10'd0 || obs4 !== 10'd0) begin
            n_err++; $display("FAIL reset_outs cyc%0d got %b/%b exp 0", c, obs, obs4);
         end
         n_cmp++;
         if (redirect_pc_o !== '0 || stall_cycles_o !== '0 || cnt4 !== '0) begin
            n_err++; $display("FAIL reset_regs got pc=%h cnt=%0d cnt4=%0d exp 0", redirect_pc_o, stall_cycles_o, cnt4);
         end
      end
      set_quiet();
   endtask

   task automatic test_res_stall();
      set_quiet();
      for (int c = 0; c < 3; c++) begin
         dp_valid_i = 1; dp_req_i = 4'b0001; rs_full_i = 4'b0001;
         #1;
         n_cmp++;
         if (obs !== model_outs() || stall_DP_o !== 1'b1) begin
            n_err++; $display("FAIL res_stall cyc%0d got %b exp %b", c, obs, model_outs());
         end
         tick();
      end
      n_cmp++;
      if (stall_cycles_o !== 32'd3 || 64'(stall_cycles_o) != m_cnt) begin
         n_err++; $display("FAIL res_stall_cnt got %0d exp 3", stall_cycles_o);
      end
      rs_full_i = 4'b0010;
      #1;
      n_cmp++;
      if (obs !== model_outs() || stall_IF_o !== 1'b0) begin
         n_err++; $display("FAIL res_nostall got %b exp %b", obs, model_outs());
      end
      tick();
      set_quiet();
   endtask

   task automatic test_serialize();
      int drain_cycles = 0;
      set_quiet();
      for (int c = 0; c < 7; c++) begin
         dp_valid_i = 1; dp_serialize_i = 1; rob_empty_i = (c >= 4);
         #1;
         if (state_o == 2'd3) drain_cycles++;
         n_cmp++;
         if (obs !== model_outs()) begin
            n_err++; $display("FAIL serialize cyc%0d got %b exp %b", c, obs, model_outs());
         end
         tick();
      end
      n_cmp++;
      if (drain_cycles != 4) begin
         n_err++; $display("FAIL serialize_drain_len got %0d exp 4", drain_cycles);
      end
      set_quiet();
   endtask

   task automatic test_mispredict();
      set_quiet();
      br_valid_i = 1; br_mispredict_i = 1; br_target_i = 32'h8000_0040;
      tick();
      set_quiet();
      n_cmp++;
      if (kill_IF_o !== 1'b1 || redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0040) begin
         n_err++; $display("FAIL mispredict_flush got kill=%b rv=%b pc=%h exp 1 1 80000040",
                           kill_IF_o, redirect_valid_o, redirect_pc_o);
      end
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++;
         if (obs !== model_outs() || redirect_pc_o !== m_pc) begin
            n_err++; $display("FAIL mispredict_seq cyc%0d got %b exp %b", c, obs, model_outs());
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      set_quiet();
      br_valid_i = 1; br_mispredict_i = 1; br_target_i = 32'h8000_0040;
      tick();                               // now FLUSH
      set_quiet();
      tick();                               // now RECOVER, first cycle
      br_valid_i = 1; br_mispredict_i = 1; br_target_i = 32'h8000_0100;
      #1;
      n_cmp++;
      if (state_o !== 2'd2 || obs !== model_outs()) begin
         n_err++; $display("FAIL b2b_recover got %b exp %b", obs, model_outs());
      end
      tick();
      set_quiet();
      n_cmp++;
      if (state_o !== 2'd1 || redirect_pc_o !== 32'h8000_0100) begin
         n_err++; $display("FAIL b2b_reflush got st=%0d pc=%h exp 1 80000100", state_o, redirect_pc_o);
      end
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++;
         if (obs !== model_outs()) begin
            n_err++; $display("FAIL b2b_seq cyc%0d got %b exp %b", c, obs, model_outs());
         end
         tick();
      end
   endtask

   task automatic test_drain_mispredict();
      set_quiet();
      dp_valid_i = 1; dp_serialize_i = 1; rob_empty_i = 0; rob_full_i = 1;
      tick();
      br_valid_i = 1; br_mispredict_i = 1; br_target_i = 32'h8000_0200;
      #1;
      n_cmp++;
      if (state_o !== 2'd3 || obs !== model_outs()) begin
         n_err++; $display("FAIL drain_misp_pre got %b exp %b", obs, model_outs());
      end
      tick();
      n_cmp++;
      if (state_o !== 2'd1 || kill_DP_o !== 1'b1 || stall_DP_o !== 1'b0 || redirect_pc_o !== 32'h8000_0200) begin
         n_err++; $display("FAIL drain_misp_flush got %b pc=%h exp FLUSH 80000200", obs, redirect_pc_o);
      end
      set_quiet();
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_saturation();
      set_quiet();
      for (int c = 0; c < 20; c++) begin
         dp_valid_i = 1; rrf_allocatable_i = 0;
         tick();
      end
      n_cmp++;
      if (cnt4 !== 4'd15 || 32'(m_cnt4) != 32'(cnt4)) begin
         n_err++; $display("FAIL sat_cnt4 got %0d exp 15", cnt4);
      end
      n_cmp++;
      if (64'(stall_cycles_o) != m_cnt) begin
         n_err++; $display("FAIL sat_cnt32 got %0d exp %0d", stall_cycles_o, m_cnt);
      end
      set_quiet();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         randomize_inputs();
         reset_i = ($urandom_range(0, 39) == 0);
         #1;
         n_cmp++;
         if (obs !== model_outs() || obs4 !== model_outs()) begin
            n_err++; $display("FAIL rand_outs cyc%0d got %b/%b exp %b", c, obs, obs4, model_outs());
         end
         tick();
         n_cmp++;
         if (redirect_pc_o !== m_pc || 64'(stall_cycles_o) != m_cnt || 32'(cnt4) != 32'(m_cnt4)) begin
            n_err++; $display("FAIL rand_regs cyc%0d got pc=%h cnt=%0d cnt4=%0d exp pc=%h cnt=%0d cnt4=%0d",
                              c, redirect_pc_o, stall_cycles_o, cnt4, m_pc, m_cnt, m_cnt4);
         end
      end
      set_quiet();
   endtask

   initial begin
      m_flush = 0; m_drain = 0; m_rec = 0; m_pc = '0; m_cnt = 0; m_cnt4 = 0;
      set_quiet();
      test_reset();
      test_res_stall();
      test_serialize();
      test_mispredict();
      test_back_to_back();
      test_drain_mispredict();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
